// File: rtl/sad_best_match.sv
// sad_best_match: accumulate row SADs per candidate block and track the minimum block SAD and its index
module sad_best_match #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int ROWS   = 4,
  parameter int CANDS  = 4,
  localparam int SW = WIDTH + $clog2(INPUTS),
  localparam int AW = SW + $clog2(ROWS),
  localparam int IW = CANDS > 1 ? $clog2(CANDS) : 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] sad_in,
  input  logic          sad_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] best_sad,
  output logic [IW-1:0] best_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [AW-1:0] acc;
  logic [RW-1:0] row;
  logic [IW-1:0] cand;
  logic [AW-1:0] total;
  logic          last_row;
  logic          last_cand;
  // block total including the row arriving this cycle
  always_comb begin
    total     = acc + AW'(sad_in);
    last_row  = row == RW'(ROWS - 1);
    last_cand = cand == IW'(CANDS - 1);
  end
  // search FSM: accumulate rows, compare on each block's final row, pulse done after the last candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      row      <= '0;
      cand     <= '0;
      best_sad <= '0;
      best_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= '0;
            row   <= '0;
            cand  <= '0;
          end
        end
        RUN: begin
          if (sad_valid) begin
            if (last_row) begin
              if (cand == '0 || total < best_sad) begin
                best_sad <= total;
                best_idx <= cand;
              end
              acc  <= '0;
              row  <= '0;
              cand <= cand + IW'(1);
              if (last_cand) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              acc <= total;
              row <= row + RW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sad_best_match.sv
// tb_sad_best_match: directed scoreboard bench for sad_best_match
module tb_sad_best_match;
  localparam int SW = 10;
  localparam int AW = 12;
  localparam int IW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sad_valid = 1'b0;
  logic [SW-1:0] sad_in = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] best_sad;
  logic [IW-1:0] best_idx;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {int sad; int idx;} exp_t;
  exp_t sb[$];
  typedef int rows_t [16];
  rows_t min_tie  = '{10, 10, 10, 10, 3, 3, 3, 3, 5, 10, 5, 10, 0, 6, 6, 0};
  rows_t all_max  = '{1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020, 1020};
  rows_t last_win = '{20, 10, 10, 10, 50, 0, 0, 0, 12, 13, 12, 13, 0, 0, 0, 0};

  always #5 clk = ~clk;

  sad_best_match #(.WIDTH(8), .INPUTS(4), .ROWS(4), .CANDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sad_in(sad_in), .sad_valid(sad_valid),
    .busy(busy), .done(done), .best_sad(best_sad), .best_idx(best_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input rows_t v);
    exp_t e;
    int t;
    e.sad = 0;
    e.idx = 0;
    for (int c = 0; c < 4; c++) begin
      t = v[4*c] + v[4*c+1] + v[4*c+2] + v[4*c+3];
      if (c == 0 || t < e.sad) begin
        e.sad = t;
        e.idx = c;
      end
    end
    return e;
  endfunction

  task automatic search(input string tag, input rows_t v, input int bubbles, input int start_at);
    exp_t e;
    sb.push_back(model(v));
    @(negedge clk);
    sad_valid = 1'b1;
    sad_in = 10'd777;
    @(negedge clk);
    chk({tag, "_idle_valid_ignored"}, {31'd0, busy}, 0);
    start = 1'b1;
    sad_in = 10'd555;
    @(negedge clk);
    start = 1'b0;
    sad_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    for (int i = 0; i < 16; i++) begin
      repeat (bubbles) begin
        sad_valid = 1'b0;
        @(negedge clk);
      end
      sad_valid = 1'b1;
      sad_in = SW'(v[i]);
      start = (i == start_at);
      @(negedge clk);
      start = 1'b0;
      sad_valid = 1'b0;
      if (i < 15) begin
        chk({tag, "_no_early_done"}, {31'd0, done}, 0);
        chk({tag, "_busy_run"}, {31'd0, busy}, 1);
      end
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 0);
    chk({tag, "_best_sad"}, {20'd0, best_sad}, e.sad);
    chk({tag, "_best_idx"}, {30'd0, best_idx}, e.idx);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 0);
    chk({tag, "_best_sad_hold"}, {20'd0, best_sad}, e.sad);
    chk({tag, "_best_idx_hold"}, {30'd0, best_idx}, e.idx);
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_best_sad", {20'd0, best_sad}, 0);
    chk("rst_best_idx", {30'd0, best_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    search("min_tie", min_tie, 0, -1);
    search("width", all_max, 0, -1);
    search("gaps", min_tie, 2, -1);
    search("last_win", last_win, 0, -1);
    search("ign_start", min_tie, 0, 9);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sad_valid = 1'b1;
      sad_in = SW'(100 + i);
      @(negedge clk);
    end
    sad_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_best_sad", {20'd0, best_sad}, 0);
    chk("midrst_best_idx", {30'd0, best_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 0);
    end
    search("after_rst", last_win, 1, -1);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sad_best_match.md
SAD_BEST_MATCH -- requirements
Module: sad_best_match

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: pixel width in bits.
REQ-002 The block SHALL have parameter INPUTS, default 4: pixels per row, so each row SAD is SW = WIDTH+$clog2(INPUTS) bits wide.
REQ-003 The block SHALL have parameter ROWS, default 4: row SADs per candidate block.
REQ-004 The block SHALL have parameter CANDS, default 4: candidate blocks per search.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset; all state is cleared while it is high.
REQ-007 The block SHALL have port start, input, 1 bit: pulse that begins a search.
REQ-008 The block SHALL have port sad_in, input, SW bits: one registered row SAD from the SAD datapath.
REQ-009 The block SHALL have port sad_valid, input, 1 bit: sad_in is valid in this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a search is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that the result is valid.
REQ-012 The block SHALL have port best_sad, output, AW = SW+$clog2(ROWS) bits: the minimum block SAD.
REQ-013 The block SHALL have port best_idx, output, $clog2(CANDS) bits: the index of the winning candidate.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to RUN on the next edge and clear the accumulator, the row counter and the candidate counter; busy SHALL be 1 from that edge.
REQ-016 In RUN, each cycle with sad_valid=1 SHALL add sad_in into the AW-bit accumulator and increment the row counter.
REQ-016a In RUN, cycles with sad_valid=0 SHALL hold all state.
REQ-017 The accumulator SHALL be AW bits wide and SHALL never overflow; the maximum value ROWS*INPUTS*(2^WIDTH-1) fits in AW bits.
REQ-018 On the sad_valid cycle with row counter = ROWS-1, the block total T = acc+sad_in SHALL be compared against best_sad in the same edge.
REQ-019 If the candidate counter is 0, or if T < best_sad (strict), the block SHALL load best_sad=T and best_idx=candidate counter.
REQ-020 Ties SHALL keep the earlier index.
REQ-021 After the last row of a block, the accumulator and row counter SHALL clear and the candidate counter SHALL increment.
REQ-022 When the last row of candidate CANDS-1 is consumed, the FSM SHALL go to DONE.
REQ-023 In DONE, done=1 and busy=0 SHALL hold for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be done asserted one cycle after the edge that captures the final row.
REQ-025 best_sad and best_idx SHALL hold their values until the next start and are stable while done=1.
REQ-026 start in RUN or DONE SHALL be ignored.
REQ-027 sad_valid in IDLE or DONE SHALL be ignored.
REQ-028 A start and a sad_valid in the same IDLE cycle SHALL start the search without consuming that sad_in.

Reset
REQ-029 While rst=1, asynchronously: the FSM SHALL be in IDLE; the accumulator, row counter and candidate counter SHALL be 0; best_sad, best_idx, busy and done SHALL be 0.
REQ-030 A reset mid-search SHALL abort it with no done pulse; the next start SHALL begin a fresh search.

Verification
REQ-031 The bench SHALL check reset: assert rst during RUN -> busy, done, best_sad and best_idx are 0 immediately, without waiting for a clock edge.
REQ-032 The bench SHALL check min and tie: with default parameters, candidate block totals 40, 12, 30, 12 (rows e.g. 10,10,10,10 / 3,3,3,3 / ...) -> done pulse with best_sad=12 and best_idx=1.
REQ-033 The bench SHALL check width: every row sad_in = 1020 for all candidates -> best_sad=4080, best_idx=0, no wrap.
REQ-034 The bench SHALL check gaps: the REQ-032 stream with sad_valid=0 bubbles inserted -> identical result, with done one cycle after the final valid.
REQ-035 The bench SHALL check ignored start: a start pulse during candidate 2 -> no restart, and the result matches the run without it.
REQ-036 The bench SHALL check a last-candidate win: totals 50, 50, 50, 0 -> best_sad=0, best_idx=3.
